crypto_stream_engine: RTL and testbench

Parametrised, multi-channel successor to the fixed single-channel encrypt/decrypt path. One unified cipher datapath serves NUM_CH logical byte streams. Each channel has its own 32-bit config word, holding its keys, shift settings and direction, plus its own key-rotation state. Output goes through an internal FIFO with valid/ready flow control on both sides, and the block sits between the byte source and the system output.

---
 rtl/crypto_pkg.sv | 72 +++++++
 rtl/crypto_stream_engine_fifo.sv | 68 ++++++
 rtl/crypto_stream_engine.sv | 127 ++++++++++++
 tb/tb_crypto_stream_engine.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/crypto_pkg.sv
// Shared types and pure functions for the multi-channel byte cipher.
package crypto_pkg;

    localparam int CFG_W = 32;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

    typedef struct packed {
        logic [7:0] k1;
        logic [7:0] k2;
        logic [7:0] k3;
        logic       shift_en;
        logic [2:0] rot_freq;
        logic [2:0] shift_amt;
        logic       mode;
    } cfg_t;

    typedef struct packed {
        logic [1:0] idx;
        logic [2:0] cnt;
    } key_st_t;

    function automatic logic [7:0] rotl8(input logic [7:0] d, input logic [2:0] s);
        logic [15:0] t;
        t = {d, d} << s;
        return t[15:8];
    endfunction

    function automatic logic [7:0] rotr8(input logic [7:0] d, input logic [2:0] s);
        logic [15:0] t;
        t = {d, d} >> s;
        return t[7:0];
    endfunction

    function automatic logic [7:0] key_sel(input cfg_t cfg, input logic [1:0] idx);
        logic [7:0] k;
        case (idx)
            2'd0:    k = cfg.k1;
            2'd1:    k = cfg.k2;
            default: k = cfg.k3;
        endcase
        return k;
    endfunction

    function automatic logic [7:0] cipher_byte(input logic [7:0] din, input logic [7:0] key,
                                               input cfg_t cfg);
        logic [7:0] t;
        if (cfg.mode == MODE_DEC) begin
            t = cfg.shift_en ? rotr8(din, cfg.shift_amt) : din;
            return t ^ key;
        end
        t = din ^ key;
        return cfg.shift_en ? rotl8(t, cfg.shift_amt) : t;
    endfunction

    // Key index walks 0,1,2 after rot_freq+1 bytes on the current key.
    function automatic key_st_t key_next(input key_st_t st, input logic [2:0] rot_freq);
        key_st_t n;
        n = st;
        if (st.cnt == rot_freq) begin
            n.cnt = 3'd0;
            n.idx = (st.idx == 2'd2) ? 2'd0 : 2'(st.idx + 2'd1);
        end else begin
            n.cnt = 3'(st.cnt + 3'd1);
        end
        return n;
    endfunction

endpackage

// File: rtl/crypto_stream_engine_fifo.sv
// sync_fifo: generic single-clock FIFO, pointers wrap modulo DEPTH.
// Latency: write visible at head one cycle after push; push+pop same cycle legal.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wr_dat_i,
    output logic [WIDTH-1:0]           rd_dat_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign rd_dat_o = mem[rd_ptr_q];
    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(wr_ptr_q + 1'b1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(rd_ptr_q + 1'b1);
        end
        if (do_push && !do_pop) begin
            count_d = CNT_W'(count_q + 1'b1);
        end else if (do_pop && !do_push) begin
            count_d = CNT_W'(count_q - 1'b1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wr_dat_i;
        end
    end

endmodule

// File: rtl/crypto_stream_engine.sv
// Multi-channel XOR/rotate byte cipher with per-channel keys and key rotation.
// Latency: 2 cycles accept-to-out_valid (cipher register, then FIFO write).
// Backpressure: in_ready from registered FIFO count + pipe occupancy only.
module crypto_stream_engine
    import crypto_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_wen,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic [31:0]     cfg_data_in,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CH_W-1:0] in_ch,
    input  logic [7:0]      in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CH_W-1:0] out_ch,
    output logic [7:0]      out_data,
    output logic            ch_err
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int FW    = 8 + CH_W;

    cfg_t            cfg_q [NUM_CH];
    cfg_t            cfg_d [NUM_CH];
    key_st_t         ks_q  [NUM_CH];
    key_st_t         ks_d  [NUM_CH];
    logic            pipe_v_q, pipe_v_d;
    logic [CH_W-1:0] pipe_ch_q, pipe_ch_d;
    logic [7:0]      pipe_data_q, pipe_data_d;
    logic            ch_err_q, ch_err_d;

    logic [IDX_W-1:0] in_idx, cfg_idx;
    logic             in_ch_ok, cfg_ch_ok, accept;
    cfg_t             cur_cfg;
    key_st_t          cur_ks;
    logic [7:0]       cur_key, cur_dout;

    logic [FW-1:0]    fifo_rd_dat;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [CNT_W:0]   occ;

    assign in_idx    = in_ch[IDX_W-1:0];
    assign cfg_idx   = cfg_ch[IDX_W-1:0];
    assign in_ch_ok  = ({1'b0, in_ch} < (CH_W + 1)'(NUM_CH));
    assign cfg_ch_ok = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));

    // Pipe slot counts as occupied so the FIFO can absorb it even if the consumer stalls.
    assign occ      = {1'b0, fifo_count} + {{CNT_W{1'b0}}, pipe_v_q};
    assign in_ready = (occ < (CNT_W + 1)'(DEPTH));
    assign accept   = in_valid && in_ready;

    assign cur_cfg  = cfg_q[in_idx];
    assign cur_ks   = ks_q[in_idx];
    assign cur_key  = key_sel(cur_cfg, cur_ks.idx);
    assign cur_dout = cipher_byte(in_data, cur_key, cur_cfg);

    always_comb begin
        cfg_d       = cfg_q;
        ks_d        = ks_q;
        pipe_v_d    = accept && in_ch_ok;
        pipe_ch_d   = pipe_ch_q;
        pipe_data_d = pipe_data_q;
        ch_err_d    = ch_err_q || (accept && !in_ch_ok);
        if (accept && in_ch_ok) begin
            ks_d[in_idx] = key_next(cur_ks, cur_cfg.rot_freq);
            pipe_ch_d    = in_ch;
            pipe_data_d  = cur_dout;
        end
        // A config write lands after the byte update so it wins on a same-channel collision.
        if (cfg_wen && cfg_ch_ok) begin
            cfg_d[cfg_idx] = cfg_t'(cfg_data_in);
            ks_d[cfg_idx]  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cfg_q[i] <= '0;
                ks_q[i]  <= '0;
            end
            pipe_v_q    <= 1'b0;
            pipe_ch_q   <= '0;
            pipe_data_q <= '0;
            ch_err_q    <= 1'b0;
        end else begin
            cfg_q       <= cfg_d;
            ks_q        <= ks_d;
            pipe_v_q    <= pipe_v_d;
            pipe_ch_q   <= pipe_ch_d;
            pipe_data_q <= pipe_data_d;
            ch_err_q    <= ch_err_d;
        end
    end

    assign fifo_pop = out_valid && out_ready;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .push_i   (pipe_v_q),
        .pop_i    (fifo_pop),
        .wr_dat_i ({pipe_ch_q, pipe_data_q}),
        .rd_dat_o (fifo_rd_dat),
        .count_o  (fifo_count),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    // Storage is not reset, so the head is masked while empty.
    assign out_valid = !fifo_empty;
    assign out_ch    = fifo_empty ? '0 : fifo_rd_dat[FW-1:8];
    assign out_data  = fifo_empty ? 8'h00 : fifo_rd_dat[7:0];
    assign ch_err    = ch_err_q;

endmodule

// File: tb/tb_crypto_stream_engine.sv
// Directed bench for crypto_stream_engine; CH_W widened to 3 so out-of-range channels are drivable.
module tb_crypto_stream_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_wen = 1'b0;
    logic [2:0]  cfg_ch = '0;
    logic [31:0] cfg_data_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_ch = '0;
    logic [7:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  out_ch;
    logic [7:0]  out_data;
    logic        ch_err;

    int tests = 0;
    int fails = 0;
    logic [10:0] got[$];

    crypto_stream_engine #(
        .NUM_CH (4),
        .DEPTH  (4),
        .CH_W   (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_wen     (cfg_wen),
        .cfg_ch      (cfg_ch),
        .cfg_data_in (cfg_data_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ch       (in_ch),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ch      (out_ch),
        .out_data    (out_data),
        .ch_err      (ch_err)
    );

    always #5 clk = ~clk;

    // Record every byte that will be popped on the coming rising edge.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) got.push_back({out_ch, out_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cfg(input logic [2:0] ch, input logic [31:0] d);
        cfg_wen = 1'b1; cfg_ch = ch; cfg_data_in = d;
        tick();
        cfg_wen = 1'b0;
    endtask

    task automatic send(input logic [2:0] ch, input logic [7:0] d);
        bit done;
        done = 1'b0;
        in_valid = 1'b1; in_ch = ch; in_data = d;
        for (int i = 0; i < 100 && !done; i++) begin
            if (in_ready) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_got(input string tag, input int n);
        int k;
        k = 0;
        while (got.size() < n && k < 200) begin
            tick();
            k++;
        end
        check(tag, 32'(got.size() >= n), 32'd1);
    endtask

    logic [7:0] src [16] = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h80, 8'h3C, 8'hC3,
                             8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    logic [7:0] enc [16];
    logic [7:0] exp_rot [4] = '{8'h11, 8'h22, 8'h33, 8'h11};
    logic [7:0] exp_shf [3] = '{8'hE1, 8'hE1, 8'h1E};

    initial begin
        int  acc;
        bit  r;
        bit  all_ch2;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_ch", out_ch, 3'd0);
        check("rst_ch_err", ch_err, 1'b0);
        @(posedge clk); #1; rst = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1'b1);

        // Passthrough and 2-cycle latency
        in_valid = 1'b1; in_ch = 3'd0; in_data = 8'hA5;
        tick();
        in_valid = 1'b0;
        check("lat_e0_valid", out_valid, 1'b0);
        tick();
        check("lat_e1_valid", out_valid, 1'b1);
        check("lat_e1_data", out_data, 8'hA5);
        check("lat_e1_ch", out_ch, 3'd0);
        out_ready = 1'b1;
        tick(); tick();
        got.delete();

        // Key rotation every byte
        do_cfg(3'd1, 32'h11223300);
        for (int i = 0; i < 4; i++) send(3'd1, 8'h00);
        wait_got("rot_count", 4);
        for (int i = 0; i < 4; i++) check($sformatf("rot_%0d", i), got[i], {3'd1, exp_rot[i]});
        got.delete();

        // Rotate-left by 1, key change after two bytes
        do_cfg(3'd0, 32'hFF000092);
        for (int i = 0; i < 3; i++) send(3'd0, 8'h0F);
        wait_got("shf_count", 3);
        for (int i = 0; i < 3; i++) check($sformatf("shf_%0d", i), got[i], {3'd0, exp_shf[i]});
        got.delete();

        // Round trip between opposite-direction channels sharing keys and shifts
        do_cfg(3'd2, 32'h5A3CC3B7);
        do_cfg(3'd3, 32'h5A3CC3B6);
        for (int i = 0; i < 16; i++) send(3'd2, src[i]);
        wait_got("rt_enc_count", 16);
        all_ch2 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            enc[i] = got[i][7:0];
            if (got[i][10:8] != 3'd2) all_ch2 = 1'b0;
        end
        check("rt_enc_ch", all_ch2, 1'b1);
        got.delete();
        for (int i = 0; i < 16; i++) send(3'd3, enc[i]);
        wait_got("rt_dec_count", 16);
        for (int i = 0; i < 16; i++) check($sformatf("rt_%0d", i), got[i], {3'd3, src[i]});
        got.delete();

        // Out-of-range channel
        send(3'd5, 8'h77);
        repeat (5) tick();
        check("bad_ch_no_out", got.size(), 32'd0);
        check("bad_ch_err", ch_err, 1'b1);

        // Config write on the same edge as an accept on that channel
        do_cfg(3'd1, 32'h11223300);
        check("same_edge_ready", in_ready, 1'b1);
        cfg_wen = 1'b1; cfg_ch = 3'd1; cfg_data_in = 32'h44556600;
        in_valid = 1'b1; in_ch = 3'd1; in_data = 8'h00;
        tick();
        cfg_wen = 1'b0; in_valid = 1'b0;
        send(3'd1, 8'h00);
        wait_got("same_edge_count", 2);
        check("same_edge_old", got[0], {3'd1, 8'h11});
        check("same_edge_new", got[1], {3'd1, 8'h44});
        got.delete();

        // Asynchronous reset mid-burst
        out_ready = 1'b0;
        in_valid = 1'b1; in_ch = 3'd0; in_data = 8'h0F;
        repeat (3) tick();
        check("pre_rst_valid", out_valid, 1'b1);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_data", out_data, 8'h00);
        check("mid_rst_err", ch_err, 1'b0);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("post_rst_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        got.delete();
        send(3'd0, 8'h3C);
        wait_got("post_rst_count", 1);
        check("post_rst_pass", got[0], {3'd0, 8'h3C});
        repeat (3) tick();
        got.delete();

        // Backpressure: exactly DEPTH accepts, then drain in order at full rate
        out_ready = 1'b0;
        in_valid = 1'b1; in_ch = 3'd0; in_data = 8'h00;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            r = in_ready;
            tick();
            if (r) begin acc++; in_data = 8'(in_data + 1); end
        end
        check("bp_accepts", acc, 32'd4);
        check("bp_ready_low", in_ready, 1'b0);
        check("bp_no_pop", got.size(), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            r = in_ready;
            tick();
            if (r) in_data = 8'(in_data + 1);
        end
        in_valid = 1'b0;
        check("bp_rate", got.size(), 32'd16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            check($sformatf("bp_%0d", i), got[i], {3'd0, 8'(i)});
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
